// File: rtl/aes_ark_pkg.sv
// Shared constants, types and helpers for the AddRoundKey stage.
package aes_ark_pkg;

    localparam int unsigned NR_AES128 = 10;
    localparam int unsigned NR_AES192 = 12;
    localparam int unsigned NR_AES256 = 14;

    typedef logic [7:0] byte_t;

    // Smallest round-counter width able to hold round index nr.
    function automatic int unsigned rw_for_nr(input int unsigned nr);
        return $clog2(nr + 1);
    endfunction

endpackage

// File: rtl/aes_ark_skid.sv
// Generic 2-entry skid buffer: output register plus one skid slot, registered ready.
module aes_ark_skid #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         skid_valid;
    logic [W-1:0] skid_data;
    logic         accept;
    logic         emit;

    assign in_ready = ~skid_valid;
    assign accept   = in_valid & in_ready;
    assign emit     = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (skid_valid) begin
            // Skid full blocks input, so the only move is draining it forward.
            if (emit) begin
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end
        end else if (accept) begin
            if (!out_valid || emit) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
            end else begin
                skid_data  <= in_data;
                skid_valid <= 1'b1;
            end
        end else if (emit) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/aes_ark_stage.sv
// AddRoundKey stage with round tagging and skid-buffered handshakes.
// Define AES_ARK_PARITY_EN to add per-byte even parity output par_o.
module aes_ark_stage
    import aes_ark_pkg::*;
#(
    parameter int unsigned NB = 16,
    parameter int unsigned NR = NR_AES128,
    parameter int unsigned RW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            ld_i,
    input  logic [8*NB-1:0] text_in,
    input  logic [8*NB-1:0] sa_i,
    input  logic [8*NB-1:0] w_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [8*NB-1:0] sa_o,
    output logic [RW-1:0]   rnd_o,
    output logic            last_o,
    output logic            seq_err_o
`ifdef AES_ARK_PARITY_EN
    ,
    output logic [NB-1:0]   par_o
`endif
);

    localparam logic [RW-1:0] NR_R = RW'(NR);

`ifdef AES_ARK_PARITY_EN
    localparam int unsigned PW = 8*NB + RW + 1 + NB;
`else
    localparam int unsigned PW = 8*NB + RW + 1;
`endif

    logic [8*NB-1:0] ark;
    logic [RW-1:0]   cnt;
    logic [RW-1:0]   tag;
    logic            tag_last;
    logic            final_sent;
    logic            accept;
    logic [PW-1:0]   in_pl;
    logic [PW-1:0]   out_pl;

    assign ark      = (ld_i ? text_in : sa_i) ^ w_i;
    assign tag      = ld_i ? '0 : cnt;
    assign tag_last = (tag == NR_R);
    assign accept   = in_valid & in_ready;

    // final_sent remembers that round NR was already issued since the last load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            final_sent <= 1'b0;
            seq_err_o  <= 1'b0;
        end else if (accept) begin
            if (ld_i) begin
                cnt        <= RW'(1);
                final_sent <= 1'b0;
                seq_err_o  <= 1'b0;
            end else begin
                if (cnt != NR_R) begin
                    cnt <= cnt + RW'(1);
                end else begin
                    final_sent <= 1'b1;
                    if (final_sent) begin
                        seq_err_o <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef AES_ARK_PARITY_EN
    logic [NB-1:0] par_in;

    always_comb begin
        par_in = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            par_in[i] = ^byte_t'(ark[8*i +: 8]);
        end
    end

    assign in_pl = {ark, tag, tag_last, par_in};
    assign {sa_o, rnd_o, last_o, par_o} = out_pl;
`else
    assign in_pl = {ark, tag, tag_last};
    assign {sa_o, rnd_o, last_o} = out_pl;
`endif

    aes_ark_skid #(
        .W(PW)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_pl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_pl)
    );

endmodule

// File: tb/tb_aes_ark_stage.sv
// Directed self-checking bench for aes_ark_stage (NB=16, NR=10, RW=4).
module tb_aes_ark_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         ld_i;
    logic [127:0] text_in;
    logic [127:0] sa_i;
    logic [127:0] w_i;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] sa_o;
    logic [3:0]   rnd_o;
    logic         last_o;
    logic         seq_err_o;
`ifdef AES_ARK_PARITY_EN
    logic [15:0]  par_o;
`endif

    always #5 clk = ~clk;

    aes_ark_stage #(
        .NB(16),
        .NR(10),
        .RW(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ld_i      (ld_i),
        .text_in   (text_in),
        .sa_i      (sa_i),
        .w_i       (w_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sa_o      (sa_o),
        .rnd_o     (rnd_o),
        .last_o    (last_o),
        .seq_err_o (seq_err_o)
`ifdef AES_ARK_PARITY_EN
        ,
        .par_o     (par_o)
`endif
    );

    typedef struct {
        logic [127:0] sa;
        logic [3:0]   rnd;
        logic         last;
    } beat_t;

    beat_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Score any output handshake happening at the coming edge, then advance one cycle.
    task automatic tick();
        beat_t b;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {124'd0, rnd_o}, 128'hffff);
            end else begin
                b = exp_q.pop_front();
                check("sa_o", sa_o, b.sa);
                check("rnd_o", {124'd0, rnd_o}, {124'd0, b.rnd});
                check("last_o", {127'd0, last_o}, {127'd0, b.last});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input logic ld, input logic [127:0] data, input logic [127:0] key,
                             input logic [3:0] exp_rnd);
        beat_t b;
        int    waited = 0;
        in_valid = 1'b1;
        ld_i     = ld;
        text_in  = ld ? data : ~data;
        sa_i     = ld ? ~data : data;
        w_i      = key;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", {127'd0, in_ready}, 128'd1);
        end else begin
            b.sa   = data ^ key;
            b.rnd  = exp_rnd;
            b.last = (exp_rnd == 4'd10);
            exp_q.push_back(b);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while ((exp_q.size() != 0 || out_valid) && n < 30) begin
            tick();
            n++;
        end
        check("drain_empty", {96'd0, exp_q.size()}, 128'd0);
        check("drain_out_valid", {127'd0, out_valid}, 128'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        ld_i      = 1'b0;
        text_in   = '0;
        sa_i      = '0;
        w_i       = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_in_ready", {127'd0, in_ready}, 128'd1);
        check("rst_sa_o", sa_o, 128'd0);
        check("rst_rnd_o", {124'd0, rnd_o}, 128'd0);
        check("rst_last_o", {127'd0, last_o}, 128'd0);
        check("rst_seq_err", {127'd0, seq_err_o}, 128'd0);
        rst = 1'b0;
        tick();

        // Initial-round xor, one-cycle latency.
        push_beat(1'b1, 128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f, 4'd0);
        check("t1_out_valid", {127'd0, out_valid}, 128'd1);
        check("t1_sa_o", sa_o, 128'h00102030405060708090a0b0c0d0e0f0);
        check("t1_rnd_o", {124'd0, rnd_o}, 128'd0);
        drain();

        // Full AES-128 sequence back to back, then an extra round beat.
        push_beat(1'b1, 128'h0123456789abcdeffedcba9876543210, 128'h0f0e0d0c0b0a09080706050403020100, 4'd0);
        for (int i = 1; i <= 10; i++) begin
            push_beat(1'b0, {4{32'h11111111 * i}}, {16{8'(i * 3)}}, 4'(i));
            check("t2_stream_valid", {127'd0, out_valid}, 128'd1);
        end
        check("t2_seq_err_clear", {127'd0, seq_err_o}, 128'd0);
        push_beat(1'b0, 128'hdeadbeefcafef00d0badc0de12345678, 128'h5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a, 4'd10);
        drain();
        check("t4_seq_err_set", {127'd0, seq_err_o}, 128'd1);
        push_beat(1'b1, 128'h1, 128'h2, 4'd0);
        drain();
        check("t4_seq_err_cleared", {127'd0, seq_err_o}, 128'd0);

        // Backpressure: output reg plus skid fill, then release.
        out_ready = 1'b0;
        push_beat(1'b1, 128'haaaa0000bbbb1111cccc2222dddd3333, 128'h0101, 4'd0);
        check("t3_in_ready_after_1", {127'd0, in_ready}, 128'd1);
        push_beat(1'b0, 128'h00000000000000000000000000000abc, 128'h0202, 4'd1);
        check("t3_in_ready_after_2", {127'd0, in_ready}, 128'd0);
        in_valid = 1'b1;
        ld_i     = 1'b0;
        sa_i     = 128'h77;
        w_i      = 128'h0303;
        tick();
        check("t3_hold_sa_o", sa_o, 128'haaaa0000bbbb1111cccc2222dddd3333 ^ 128'h0101);
        check("t3_hold_ready", {127'd0, in_ready}, 128'd0);
        tick();
        check("t3_hold_valid", {127'd0, out_valid}, 128'd1);
        out_ready = 1'b1;
        push_beat(1'b0, 128'h77, 128'h0303, 4'd2);
        drain();

        // Reload mid-sequence restarts at round 0.
        push_beat(1'b0, 128'h10, 128'h01, 4'd3);
        push_beat(1'b1, 128'h20, 128'h02, 4'd0);
        push_beat(1'b0, 128'h30, 128'h03, 4'd1);
        drain();

`ifdef AES_ARK_PARITY_EN
        out_ready = 1'b0;
        push_beat(1'b1, 128'h0307, 128'h0, 4'd0);
        check("t6_par_o", {112'd0, par_o}, 128'h0001);
        drain();
`endif

        // Asynchronous reset with two beats buffered.
        out_ready = 1'b0;
        push_beat(1'b1, 128'h1234, 128'h4321, 4'd0);
        push_beat(1'b0, 128'h5678, 128'h8765, 4'd1);
        check("t5_pre_ready", {127'd0, in_ready}, 128'd0);
        #2;
        rst = 1'b1;
        #1;
        check("t5_out_valid", {127'd0, out_valid}, 128'd0);
        check("t5_in_ready", {127'd0, in_ready}, 128'd1);
        check("t5_rnd_o", {124'd0, rnd_o}, 128'd0);
        check("t5_sa_o", sa_o, 128'd0);
        exp_q.delete();
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        // Counter restarts from 0 after reset, so a round beat is tagged 0.
        out_ready = 1'b1;
        push_beat(1'b0, 128'h99, 128'h66, 4'd0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
